dsc_mul_nway: RTL and testbench

- Parametrised deterministic stochastic-computing (DSC) multiplier: exact product of N_IN unsigned WIDTH-bit operands.
- Uses serial clock-division unary streams: a cascaded counter chain on a single clock, a compare per operand, an AND and a ones-counter.
- Successor to the fixed 3-input, 10-bit naive serial multiplier. Adds start/busy/done handshake, run/pause enable, parametrised width and input count, and optional early termination.
- Sits in the DSC datapath wherever a binary-in/binary-out product is needed.

---
 rtl/dsc_mul_nway_if.sv | 30 +++
 rtl/dsc_mul_nway.sv | 123 ++++++++++++
 tb/tb_dsc_mul_nway.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/dsc_mul_nway_if.sv
// Handshake and operand bus for the N-way deterministic stochastic-computing multiplier.
interface dsc_mul_nway_if #(
    parameter int unsigned N_IN  = 3,
    parameter int unsigned WIDTH = 10
);
    logic                    en;
    logic                    start;
    logic [N_IN*WIDTH-1:0]   ops;
    logic [N_IN*WIDTH-1:0]   z;
    logic                    busy;
    logic                    done;

    modport master (
        output en,
        output start,
        output ops,
        input  z,
        input  busy,
        input  done
    );

    modport slave (
        input  en,
        input  start,
        input  ops,
        output z,
        output busy,
        output done
    );
endinterface

// File: rtl/dsc_mul_nway.sv
// Exact N-way product using clock-division unary streams and a ones-counter.
// Optional early termination is enabled by defining DSC_MUL_EARLY_TERM_EN.
module dsc_mul_nway #(
    parameter int unsigned N_IN  = 3,
    parameter int unsigned WIDTH = 10
) (
    input logic           clk,
    input logic           rst_n,
    dsc_mul_nway_if.slave bus
);
    localparam int unsigned      AccW   = N_IN * WIDTH;
    localparam logic [WIDTH-1:0] CtrMax = '1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] op_q  [N_IN];
    logic [WIDTH-1:0] op_d  [N_IN];
    logic [WIDTH-1:0] ctr_q [N_IN];
    logic [WIDTH-1:0] ctr_d [N_IN];
    logic [AccW-1:0]  acc_q, acc_d;
    logic [AccW-1:0]  z_q, z_d;

    logic [N_IN-1:0]  carry;
    logic [N_IN-1:0]  stream;
    logic             prod_bit;
    logic             last;
    logic             finish;

    // carry[k]: every lower counter sits at its maximum, so ctr[k] advances this cycle.
    always_comb begin : chain
        logic run_c;
        run_c = 1'b1;
        for (int k = 0; k < N_IN; k++) begin
            carry[k]  = run_c;
            run_c     = run_c && (ctr_q[k] == CtrMax);
            stream[k] = op_q[k] > ctr_q[k];
        end
        last     = run_c;
        prod_bit = &stream;
    end

`ifdef DSC_MUL_EARLY_TERM_EN
    logic [WIDTH:0] top_next;
    logic           any_zero;

    // Once the top counter reaches its operand every later stream bit is 0.
    always_comb begin : early
        top_next = {1'b0, ctr_q[N_IN-1]} + (WIDTH+1)'(1);
        finish   = last || (carry[N_IN-1] && (top_next == {1'b0, op_q[N_IN-1]}));
        any_zero = 1'b0;
        for (int k = 0; k < N_IN; k++) begin
            any_zero = any_zero || (bus.ops[k*WIDTH +: WIDTH] == '0);
        end
    end
`else
    assign finish = last;
`endif

    always_comb begin : fsm
        state_d = state_q;
        op_d    = op_q;
        ctr_d   = ctr_q;
        acc_d   = acc_q;
        z_d     = z_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    for (int k = 0; k < N_IN; k++) begin
                        op_d[k]  = bus.ops[k*WIDTH +: WIDTH];
                        ctr_d[k] = '0;
                    end
                    acc_d   = '0;
                    state_d = StRun;
`ifdef DSC_MUL_EARLY_TERM_EN
                    if (any_zero) begin
                        z_d     = '0;
                        state_d = StDone;
                    end
`endif
                end
            end
            StRun: begin
                if (bus.en) begin
                    for (int k = 0; k < N_IN; k++) begin
                        if (carry[k]) begin
                            ctr_d[k] = ctr_q[k] + WIDTH'(1);
                        end
                    end
                    acc_d = acc_q + AccW'(prod_bit);
                    if (finish) begin
                        z_d     = acc_d;
                        state_d = StDone;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            acc_q   <= '0;
            z_q     <= '0;
            for (int k = 0; k < N_IN; k++) begin
                op_q[k]  <= '0;
                ctr_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            ctr_q   <= ctr_d;
            acc_q   <= acc_d;
            z_q     <= z_d;
        end
    end

    assign bus.busy = (state_q == StRun);
    assign bus.done = (state_q == StDone);
    assign bus.z    = z_q;
endmodule

// File: tb/tb_dsc_mul_nway.sv
// Bench for dsc_mul_nway: a 3x3-bit and a 2x4-bit instance checked every cycle
// against a cycles-remaining model; honours DSC_MUL_EARLY_TERM_EN.
`timescale 1ns/1ps
module tb_dsc_mul_nway;
`ifdef DSC_MUL_EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dsc_mul_nway_if #(.N_IN(3), .WIDTH(3)) ia ();
    dsc_mul_nway_if #(.N_IN(2), .WIDTH(4)) ib ();

    dsc_mul_nway #(.N_IN(3), .WIDTH(3)) u_a (.clk(clk), .rst_n(rst_n), .bus(ia.slave));
    dsc_mul_nway #(.N_IN(2), .WIDTH(4)) u_b (.clk(clk), .rst_n(rst_n), .bus(ib.slave));

    int checks = 0;
    int errors = 0;

    // Enabled RUN cycles an operation needs, straight from the operand values.
    function automatic int exp_lat(int n, int w, int o0, int o1, int o2);
`ifdef DSC_MUL_EARLY_TERM_EN
        int top;
        top = (n == 3) ? o2 : o1;
        if (o0 == 0 || o1 == 0 || (n == 3 && o2 == 0)) return 0;
        return top << ((n - 1) * w);
`else
        return 1 << (n * w);
`endif
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase 0 idle, 1 running, 2 done; left counts enabled cycles still owed.
    int m_phase [2];
    int m_left  [2];
    int m_prod  [2];
    int m_z     [2];

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            int o0, o1, o2, st, en_b;
            if (d == 0) begin
                st = int'(ia.start); en_b = int'(ia.en);
                o0 = int'(ia.ops[2:0]); o1 = int'(ia.ops[5:3]); o2 = int'(ia.ops[8:6]);
            end else begin
                st = int'(ib.start); en_b = int'(ib.en);
                o0 = int'(ib.ops[3:0]); o1 = int'(ib.ops[7:4]); o2 = 1;
            end
            if (!rst_n) begin
                m_phase[d] = 0;
                m_z[d]     = 0;
            end else begin
                case (m_phase[d])
                    0: if (st != 0) begin
                        m_prod[d] = o0 * o1 * o2;
                        m_left[d] = (d == 0) ? exp_lat(3, 3, o0, o1, o2) : exp_lat(2, 4, o0, o1, 1);
                        if (m_left[d] == 0) begin
                            m_phase[d] = 2;
                            m_z[d]     = m_prod[d];
                        end else begin
                            m_phase[d] = 1;
                        end
                    end
                    1: if (en_b != 0) begin
                        m_left[d]--;
                        if (m_left[d] == 0) begin
                            m_phase[d] = 2;
                            m_z[d]     = m_prod[d];
                        end
                    end
                    default: m_phase[d] = 0;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        check("a_busy", int'(ia.busy), int'(m_phase[0] == 1));
        check("a_done", int'(ia.done), int'(m_phase[0] == 2));
        check("a_z",    int'(ia.z),    m_z[0]);
        check("b_busy", int'(ib.busy), int'(m_phase[1] == 1));
        check("b_done", int'(ib.done), int'(m_phase[1] == 2));
        check("b_z",    int'(ib.z),    m_z[1]);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic get_done(input int d);
        return (d == 0) ? ia.done : ib.done;
    endfunction

    function automatic logic get_busy(input int d);
        return (d == 0) ? ia.busy : ib.busy;
    endfunction

    task automatic issue(input int d, input int o0, input int o1, input int o2, input bit hold);
        if (d == 0) ia.ops = {3'(o2), 3'(o1), 3'(o0)};
        else        ib.ops = {4'(o1), 4'(o0)};
        if (d == 0) ia.start = 1'b1; else ib.start = 1'b1;
        tick();
        if (!hold) begin
            if (d == 0) ia.start = 1'b0; else ib.start = 1'b0;
        end
    endtask

    // lat = RUN cycles between accepted start and done; optional pause and stray start on DUT a.
    task automatic wait_done(input int d, input int pause_at, output int lat, output int bc);
        lat = 0;
        bc  = 0;
        while (!get_done(d)) begin
            if (lat > 2000) begin
                checks++;
                errors++;
                $display("FAIL timeout dut%0d: waited %0d cycles, done required", d, lat);
                break;
            end
            if (get_busy(d)) bc++;
            tick();
            lat++;
            if (d == 0 && pause_at >= 0) begin
                if (lat == pause_at)      ia.en = 1'b0;
                if (lat == pause_at + 5)  begin ia.start = 1'b1; ia.ops = {3'd1, 3'd1, 3'd1}; end
                if (lat == pause_at + 6)  ia.start = 1'b0;
                if (lat == pause_at + 20) ia.en = 1'b1;
            end
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation still running, completion required");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, bc, o0, o1;
        ia.en = 1'b1; ia.start = 1'b0; ia.ops = '0;
        ib.en = 1'b1; ib.start = 1'b0; ib.ops = '0;
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_busy", int'(ia.busy), 0);
        check("rst_done", int'(ia.done), 0);
        check("rst_z",    int'(ia.z),    0);
        rst_n = 1'b1;
        tick();

        issue(0, 7, 6, 5, 1'b0);
        wait_done(0, -1, lat, bc);
        check("p765_z",   int'(ia.z), 210);
        check("p765_lat", lat, EARLY ? 320 : 512);
        check("p765_busy", bc, lat);
        tick();

        issue(0, 7, 7, 7, 1'b0);
        wait_done(0, -1, lat, bc);
        check("p777_z",   int'(ia.z), 343);
        check("p777_lat", lat, EARLY ? 448 : 512);
        tick();

        issue(0, 0, 6, 5, 1'b0);
        wait_done(0, -1, lat, bc);
        check("p065_z",   int'(ia.z), 0);
        check("p065_lat", lat, EARLY ? 0 : 512);
        tick();

        issue(0, 3, 4, 5, 1'b0);
        wait_done(0, 100, lat, bc);
        check("pause_z",   int'(ia.z), 60);
        check("pause_lat", lat, EARLY ? 340 : 532);
        check("pause_busy", bc, lat);
        tick();

        issue(0, 7, 7, 7, 1'b0);
        repeat (100) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort_busy", int'(ia.busy), 0);
        check("abort_done", int'(ia.done), 0);
        check("abort_z",    int'(ia.z),    0);
        repeat (5) tick();
        issue(0, 2, 2, 2, 1'b0);
        wait_done(0, -1, lat, bc);
        check("p222_z",   int'(ia.z), 8);
        check("p222_lat", lat, EARLY ? 128 : 512);
        tick();

        issue(0, 7, 7, 2, 1'b0);
        wait_done(0, -1, lat, bc);
        check("p772_z",   int'(ia.z), 98);
        check("p772_lat", lat, EARLY ? 128 : 512);
        tick();

        // Start held high: ops changed mid-run are ignored, then picked up by the restart.
        issue(0, 1, 2, 3, 1'b1);
        ia.ops = {3'd3, 3'd3, 3'd3};
        wait_done(0, -1, lat, bc);
        check("hold1_z",   int'(ia.z), 6);
        check("hold1_lat", lat, EARLY ? 192 : 512);
        tick();
        tick();
        check("hold_restart_busy", int'(ia.busy), 1);
        ia.start = 1'b0;
        wait_done(0, -1, lat, bc);
        check("hold2_z",   int'(ia.z), 27);
        check("hold2_lat", lat, EARLY ? 192 : 512);
        tick();

        for (int i = 0; i < 150; i++) begin
            o0 = int'($urandom_range(0, 15));
            o1 = int'($urandom_range(0, 15));
            issue(1, o0, o1, 1, 1'b0);
            wait_done(1, -1, lat, bc);
            check("rand_z",    int'(ib.z), o0 * o1);
            check("rand_lat",  lat, EARLY ? ((o0 == 0 || o1 == 0) ? 0 : o1 * 16) : 256);
            check("rand_busy", bc, lat);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
